// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: load/store access
// encodings understood by both the decoder and the memory, plus arbiter states.
package mem_arb_pkg;

  localparam logic [3:0] LS_W  = 4'b0000;
  localparam logic [3:0] LS_H  = 4'b1000;
  localparam logic [3:0] LS_B  = 4'b0100;
  localparam logic [3:0] LS_HU = 4'b0010;
  localparam logic [3:0] LS_BU = 4'b0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_wdog.sv
// Busy-cycle watchdog: expire rises during the TIMEOUT-th consecutive
// enabled cycle since the last clear.
module mem_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expire = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data stages; data has fixed
// priority, flushed fetches are discarded, and stuck accesses are aborted.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_ls,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_ls,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          err
);

  arb_state_e    state, next_state;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [3:0]    ls_q;
  logic          discard;
  logic          expire;
  logic          done;
  logic          pend_i, pend_d;
  logic          grant_i, grant_d;
  logic [DW-1:0] rdata_sel;

  // A requester whose ack is showing this cycle still holds req high; masking
  // it keeps the same transaction from being served twice.
  assign pend_d    = d_req & ~d_ack;
  assign pend_i    = i_req & ~i_ack & ~i_flush;
  assign done      = (state != IDLE) & (mem_ready | expire);
  assign rdata_sel = mem_ready ? mem_rdata : '0;

  mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (done | (state == IDLE)),
    .en     (state != IDLE),
    .expire (expire)
  );

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_d) grant_d = 1'b1;
        else if (pend_i) grant_i = 1'b1;
      end
      BUSY_I: begin
        if (done) begin
          if (pend_d) grant_d = 1'b1;
          else next_state = IDLE;
        end
      end
      BUSY_D: begin
        if (done) begin
          if (pend_i) grant_i = 1'b1;
          else next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (grant_d) next_state = BUSY_D;
    else if (grant_i) next_state = BUSY_I;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ls_q    <= LS_W;
    end else if (grant_d) begin
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
      we_q    <= d_we;
      ls_q    <= d_ls;
    end else if (grant_i) begin
      addr_q  <= i_addr;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ls_q    <= LS_W;
    end
  end

  // A flush seen on the completion edge itself also discards the fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
      discard <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if ((state == BUSY_I) && i_flush) discard <= 1'b1;
      if (done) begin
        discard <= 1'b0;
        if (state == BUSY_D) begin
          d_ack   <= 1'b1;
          d_rdata <= rdata_sel;
        end else if (!(discard | i_flush)) begin
          i_ack   <= 1'b1;
          i_rdata <= rdata_sel;
        end
        if (!mem_ready) err <= 1'b1;
      end
    end
  end

  assign mem_req   = (state != IDLE);
  assign mem_we    = (state == BUSY_D) & we_q;
  assign mem_ls    = (state == BUSY_D) ? ls_q : LS_W;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the instruction-fetch stage and the data-memory stage of the pipelined RV32I CPU. It sequences one memory transaction at a time, with data having fixed priority over instruction. It stalls the requesting pipeline stages while they wait and discards fetches cancelled by a taken branch or jump. A watchdog aborts accesses the memory never completes.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles in a busy state before abort (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  AW  fetch address
- i_flush  in  1  cancel current/pending fetch (branch taken, jal, jalr)
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  DW  fetched word, valid with i_ack, held afterwards
- d_req  in  1  data request (Memread|MemWrite); fields held until d_ack
- d_we  in  1  1 = store
- d_ls  in  4  access type: w 0000, h 1000, b 0100, hu 0010, bu 0001
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  load data, valid with d_ack
- mem_req  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_ls  out  4  access type to memory (0000 for fetches)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes current access this cycle
- stall_if  out  1  i_req & ~i_ack
- stall_mem  out  1  d_req & ~d_ack
- err  out  1  sticky watchdog-abort flag

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: the arbiter samples the requests at each edge.
  - d_req → BUSY_D.
  - Otherwise i_req & ~i_flush → BUSY_I.
  - Otherwise it stays in IDLE.
- BUSY_x: mem_req=1. mem_addr, mem_we, mem_ls and mem_wdata come from the registered request captured at grant. mem_we=d_we only in BUSY_D; mem_we=0 and mem_ls=0000 in BUSY_I.
- Completion: the arbiter samples mem_ready=1 at an edge.
  - It registers mem_rdata into i_rdata or d_rdata.
  - It pulses the matching ack next cycle.
- Re-arbitration at completion: the arbiter considers only the other requester, which prevents re-serving a requester whose req is still high in its ack cycle.
  - Other requester pending → enter its busy state directly. There is no IDLE bubble.
  - Otherwise → IDLE.
- Flush:
  - i_flush sampled in BUSY_I sets a discard flag. The memory access runs to completion, then i_ack is suppressed and i_rdata is not updated.
  - In IDLE, i_flush blocks the fetch grant that edge.
  - i_flush has no effect on BUSY_D.
- Watchdog:
  - The counter clears on entry to any busy state and increments each busy cycle.
  - Reaching TIMEOUT without mem_ready counts as a completion with rdata=0 and sets err.
  - err stays set until rst.
- Simultaneous mem_ready and timeout on the same edge: mem_ready wins and err is not set.

## Timing
- Reset values: state IDLE, mem_req, mem_we, i_ack, d_ack, err all 0; mem_ls, mem_addr, mem_wdata, i_rdata, d_rdata all 0.
- rst mid-access: mem_req drops asynchronously, no ack is issued, and the discard flag and counter clear.
- Latency: req high in cycle 0 → mem_req high cycle 1. mem_ready in cycle k≥1 → ack in cycle k+1. Minimum request-to-ack latency is 2 cycles.
- Back-to-back: the second access's mem_req stays high continuously across the completion edge.
- stall_if and stall_mem are combinational from req and ack.

## Structure
- Shared package `mem_arb_pkg`: ls encodings (LS_W, LS_H, LS_B, LS_HU, LS_BU) and state encoding. The same ls constants serve the decoder and the memory.
- One natural sub-module, `mem_wdog`: a TIMEOUT counter with clear/enable inputs and an expire output.

## Test plan
- Fetch only: i_req, i_addr=0x40 cycle 0; mem_ready=1, mem_rdata=0x00500093 in cycle 1 → i_ack and i_rdata=0x00500093 in cycle 2; mem_we=0, mem_ls=0000.
- Contention: i_req (0x44) and lw d_req (0x100) both in cycle 0; memory ready 1 cycle after each grant → mem_addr=0x100 first, d_ack in cycle 2. mem_addr=0x44 follows with no IDLE cycle; i_ack in cycle 3.
- Store byte: d_we=1, d_ls=0100, d_addr=0x203, d_wdata=0xAB → mem_we=1, mem_ls=0100, mem_addr=0x203, mem_wdata=0xAB while busy; d_ack 1 cycle after mem_ready.
- Flush: i_flush in cycle 2 of BUSY_I (addr 0x80), mem_ready in cycle 3 → no i_ack and i_rdata unchanged. The next i_req (0x200) is served normally.
- Timeout: d_req with mem_ready held low → d_ack 16 busy cycles after grant, d_rdata=0, err=1. err is still 1 after further good accesses and clears only on rst.
- Reset mid-access: rst asserted in BUSY_D → mem_req=0 immediately, no d_ack, state IDLE; after release, a new request is served normally.
